// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between IF and LS requesters
module mem_port_arbiter (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_ls_q, last_ls_d;      // 1 = LS was granted last
    logic        owner_ls_q, owner_ls_d;    // 1 = in-flight command belongs to LS
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        if_gnt_q, if_gnt_d;
    logic        ls_gnt_q, ls_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        busy_q, busy_d;
    logic        pick_ls;

    // Next-state, arbitration and registered-output computation
    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        owner_ls_d  = owner_ls_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        // On a tie the requester that did not win last time goes first
        pick_ls     = ls_req && (!if_req || !last_ls_q);

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d    = ISSUE;
                    owner_ls_d = pick_ls;
                    last_ls_d  = pick_ls;
                    if (pick_ls) begin
                        ls_gnt_d    = 1'b1;
                        mem_addr_d  = ls_addr;
                        mem_we_d    = ls_we;
                        mem_wdata_d = ls_wdata;
                        mem_wstrb_d = ls_we ? ls_wstrb : 4'b0000;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = 32'h0;
                        mem_wstrb_d = 4'b0000;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (owner_ls_q) begin
                        ls_rdata_d  = mem_rdata;
                        ls_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they come out of flops
        mem_req_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            last_ls_q   <= 1'b1;
            owner_ls_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ls_q   <= last_ls_d;
            owner_ls_q  <= owner_ls_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        CLOCK;
    logic        RESET_N;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    typedef struct {
        bit          ls;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_ls_rdata = 32'h0;
    bit          ls_known = 1'b1;

    mem_port_arbiter dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_addr    (ls_addr),
        .ls_we      (ls_we),
        .ls_wdata   (ls_wdata),
        .ls_wstrb   (ls_wstrb),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] a, input logic we,
                             input logic [31:0] wd, input logic [3:0] ws);
        check({tag, "_mem_req"},   {31'h0, mem_req}, 32'h1);
        check({tag, "_mem_addr"},  mem_addr, a);
        check({tag, "_mem_we"},    {31'h0, mem_we}, {31'h0, we});
        check({tag, "_mem_wdata"}, mem_wdata, wd);
        check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, ws});
    endtask

    task automatic check_rdata(input string tag);
        check({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
        if (ls_known) check({tag, "_ls_rdata"}, ls_rdata, exp_ls_rdata);
    endtask

    // Runs one transaction starting in IDLE with the winning request already driven
    task automatic run_txn(input string tag, input bit e_ls, input logic [31:0] e_addr,
                           input logic e_we, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                           input int stalls, input bit spur, input logic [31:0] rdata, input bit drop);
        exp_t e;
        mem_gnt = 1'b0;
        step();
        check({tag, "_if_gnt"}, {31'h0, if_gnt}, {31'h0, !e_ls});
        check({tag, "_ls_gnt"}, {31'h0, ls_gnt}, {31'h0, e_ls});
        check({tag, "_busy_issue"}, {31'h0, busy}, 32'h1);
        check_cmd({tag, "_issue"}, e_addr, e_we, e_wdata, e_wstrb);
        if (drop) begin
            if (e_ls) ls_req = 1'b0;
            else      if_req = 1'b0;
        end
        repeat (stalls) begin
            mem_rvalid = spur;
            step();
            mem_rvalid = 1'b0;
            check({tag, "_gnt_once"}, {30'h0, if_gnt, ls_gnt}, 32'h0);
            check({tag, "_no_rvalid_stall"}, {30'h0, if_rvalid, ls_rvalid}, 32'h0);
            check_cmd({tag, "_stall"}, e_addr, e_we, e_wdata, e_wstrb);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check({tag, "_wait_mem_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_wait_busy"}, {31'h0, busy}, 32'h1);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        if (!e_we) sb.push_back('{ls: e_ls, data: rdata});
        step();
        mem_rvalid = 1'b0;
        check({tag, "_if_rvalid"}, {31'h0, if_rvalid}, {31'h0, !e_ls});
        check({tag, "_ls_rvalid"}, {31'h0, ls_rvalid}, {31'h0, e_ls});
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.ls) begin
                exp_ls_rdata = e.data;
                ls_known = 1'b1;
            end else begin
                exp_if_rdata = e.data;
            end
        end else if (e_ls && e_we) begin
            ls_known = 1'b0;
        end
        check_rdata({tag, "_resp"});
        step();
        check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_idle_rvalid"}, {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   {31'h0, mem_req}, 32'h0);
        check({tag, "_mem_addr"},  mem_addr, 32'h0);
        check({tag, "_mem_we"},    {31'h0, mem_we}, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        check({tag, "_gnts"},      {30'h0, if_gnt, ls_gnt}, 32'h0);
        check({tag, "_rvalids"},   {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        check({tag, "_if_rdata"},  if_rdata, 32'h0);
        check({tag, "_ls_rdata"},  ls_rdata, 32'h0);
        check({tag, "_busy"},      {31'h0, busy}, 32'h0);
    endtask

    initial begin
        RESET_N    = 1'b0;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        ls_req     = 1'b0;
        ls_addr    = 32'h0;
        ls_we      = 1'b0;
        ls_wdata   = 32'h0;
        ls_wstrb   = 4'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge CLOCK);
        #1;
        check_all_zero("reset");
        RESET_N = 1'b1;
        step();

        // IF-only read, minimum latency
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        run_txn("if_read", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0013, 1'b1);

        // LS store with two stall cycles
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h2000_0004;
        ls_wdata = 32'hDEAD_BEEF;
        ls_wstrb = 4'h3;
        run_txn("ls_store", 1'b1, 32'h2000_0004, 1'b1, 32'hDEAD_BEEF, 4'h3, 2, 1'b0, 32'h0, 1'b1);
        ls_we    = 1'b0;
        ls_wdata = 32'h0;
        ls_wstrb = 4'h0;

        // Contention: both held, expect IF, LS, IF, LS
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        ls_req  = 1'b1;
        ls_addr = 32'h3000_0000;
        run_txn("rr0_if", 1'b0, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00A1, 1'b0);
        run_txn("rr1_ls", 1'b1, 32'h3000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00B2, 1'b0);
        run_txn("rr2_if", 1'b0, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h0000_00A3, 1'b0);
        run_txn("rr3_ls", 1'b1, 32'h3000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00B4, 1'b1);
        if_req = 1'b0;

        // Spurious response in IDLE
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        mem_rvalid = 1'b0;
        check("spur_idle_busy", {31'h0, busy}, 32'h0);
        check("spur_idle_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        check_rdata("spur_idle");
        step();
        check("spur_idle_busy2", {31'h0, busy}, 32'h0);

        // Spurious response in ISSUE before acceptance, then a real one
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        run_txn("spur_issue", 1'b0, 32'h0000_0400, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'h0000_0055, 1'b1);

        // Reset mid-WAIT abandons the transaction
        if_req  = 1'b1;
        if_addr = 32'h0000_0500;
        step();
        check("rst_pre_gnt", {31'h0, if_gnt}, 32'h1);
        if_req  = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("rst_pre_wait_busy", {31'h0, busy}, 32'h1);
        check("rst_pre_wait_req", {31'h0, mem_req}, 32'h0);
        RESET_N = 1'b0;
        #1;
        check_all_zero("rst_async");
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        ls_known     = 1'b1;
        step();
        RESET_N    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        check("rst_late_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        check("rst_late_busy", {31'h0, busy}, 32'h0);
        check_rdata("rst_late");
        step();
        check("rst_late_rvalid2", {30'h0, if_rvalid, ls_rvalid}, 32'h0);

        // After reset IF wins the first tie again
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        ls_req  = 1'b1;
        ls_addr = 32'h4000_0008;
        run_txn("post_rst_if", 1'b0, 32'h0000_0600, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0066, 1'b1);
        run_txn("post_rst_ls", 1'b1, 32'h4000_0008, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0077, 1'b1);
        check("sb_empty", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
